// File: rtl/mem_wb_stage_pkg.sv
// Shared types and encodings for the memory/writeback stage.
// Holds the handshake state enum, ResultSrc codes and the writeback result selector.
package mem_wb_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Reserved encoding 2'b11 falls back to the ALU result.
  function automatic logic [31:0] result_sel(input logic [1:0]  src,
                                             input logic [31:0] alu,
                                             input logic [31:0] mem,
                                             input logic [31:0] pc4);
    logic [31:0] res;
    case (src)
      RES_ALU: res = alu;
      RES_MEM: res = mem;
      RES_PC4: res = pc4;
      default: res = alu;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory valid/ready bus between the M stage and data memory.
// master = core side issuing requests, slave = memory side.
interface mem_wb_stage_if;

  logic        dreq_valid;
  logic        dreq_ready;
  logic        dreq_we;
  logic [31:0] dreq_addr;
  logic [31:0] dreq_wdata;
  logic        drsp_valid;
  logic [31:0] drsp_rdata;

  modport master (
    output dreq_valid,
    output dreq_we,
    output dreq_addr,
    output dreq_wdata,
    input  dreq_ready,
    input  drsp_valid,
    input  drsp_rdata
  );

  modport slave (
    input  dreq_valid,
    input  dreq_we,
    input  dreq_addr,
    input  dreq_wdata,
    output dreq_ready,
    output drsp_valid,
    output drsp_rdata
  );

endinterface

// File: rtl/dmem_handshake.sv
// Data-memory access sequencer: request/wait/done FSM with response timeout,
// captured load data and sticky misalignment / bus-timeout flags.
module dmem_handshake
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           memop,
  input  logic           we,
  input  logic [31:0]    addr,
  input  logic [31:0]    wdata,
  mem_wb_stage_if.master dbus,
  output logic           done,
  output logic           stall,
  output logic [31:0]    rdata,
  output logic           misalign_err,
  output logic           bus_err
);

  localparam logic [TO_W-1:0] CntLast = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q;
  logic [TO_W-1:0] cnt_q;
  logic [31:0]     rdata_q;
  logic            mis_q;
  logic            berr_q;
  logic            misaligned;

  assign misaligned = (addr[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (memop) begin
            if (misaligned) begin
              mis_q   <= 1'b1;
              rdata_q <= '0;
              state_q <= DONE;
            end else if (dbus.dreq_ready) begin
              state_q <= WAIT;
            end else begin
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (dbus.dreq_ready) state_q <= WAIT;
        end
        WAIT: begin
          // A response in the final timeout cycle still counts as a normal completion.
          if (dbus.drsp_valid) begin
            if (!we) rdata_q <= dbus.drsp_rdata;
            state_q <= DONE;
          end else if (cnt_q == CntLast) begin
            rdata_q <= '0;
            berr_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Request drops straight away when reset asserts, without waiting for an edge.
  assign dbus.dreq_valid = ~rst & memop & ~misaligned &
                           ((state_q == IDLE) | (state_q == REQ));
  assign dbus.dreq_we    = we;
  assign dbus.dreq_addr  = {addr[31:2], 2'b00};
  assign dbus.dreq_wdata = wdata;

  assign done         = (state_q == DONE);
  assign stall        = memop & ~done;
  assign rdata        = rdata_q;
  assign misalign_err = mis_q;
  assign bus_err      = berr_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access plus writeback stage: drives the data-memory bus for loads/stores,
// stalls the upstream pipeline while an access is outstanding, and holds the W register.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    ALUResultM,
  input  logic [31:0]    WriteDataM,
  input  logic           MemWriteM,
  input  logic [1:0]     ResultSrcM,
  input  logic           RegWriteM,
  input  logic [4:0]     RdM,
  input  logic [31:0]    PCPlus4M,
  mem_wb_stage_if.master dbus,
  output logic           StallM,
  output logic [31:0]    ResultW,
  output logic [4:0]     RdW,
  output logic           RegWriteW,
  output logic           misalign_err,
  output logic           bus_err
);

  logic        memop;
  logic        hs_done;
  logic        hs_stall;
  logic [31:0] hs_rdata;
  logic        retire;

  assign memop = MemWriteM | (ResultSrcM == RES_MEM);

  dmem_handshake #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_dmem_handshake (
    .clk          (clk),
    .rst          (reset),
    .memop        (memop),
    .we           (MemWriteM),
    .addr         (ALUResultM),
    .wdata        (WriteDataM),
    .dbus         (dbus),
    .done         (hs_done),
    .stall        (hs_stall),
    .rdata        (hs_rdata),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  assign StallM = hs_stall;
  // An M instruction leaves the stage either immediately (no memory op) or from DONE.
  assign retire = ~memop | hs_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ResultW   <= '0;
      RdW       <= '0;
      RegWriteW <= 1'b0;
    end else if (retire) begin
      ResultW   <= result_sel(ResultSrcM, ALUResultM, hs_rdata, PCPlus4M);
      RdW       <= RdM;
      RegWriteW <= RegWriteM & (RdM != 5'd0);
    end else begin
      RegWriteW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised bench for mem_wb_stage: an instruction-level timeline model predicts
// stall length, bus activity and writeback results; directed cases pin the model.
module tb_mem_wb_stage;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] pc4;
    logic [31:0] rdata;
    logic [1:0]  src;
    logic        we;
    logic        rw;
    logic        tmo;
    logic        noisy;
    logic [4:0]  rd;
    int          r;
    int          d;
  } instr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_m, wdata_m, pc4_m;
  logic        memwrite_m, regwrite_m;
  logic [1:0]  src_m;
  logic [4:0]  rd_m;
  logic        stall_w, rw_w, mis_w, berr_w;
  logic [31:0] result_w;
  logic [4:0]  rd_w;

  mem_wb_stage_if dbus ();

  mem_wb_stage dut (
    .clk          (clk),
    .reset        (reset),
    .ALUResultM   (alu_m),
    .WriteDataM   (wdata_m),
    .MemWriteM    (memwrite_m),
    .ResultSrcM   (src_m),
    .RegWriteM    (regwrite_m),
    .RdM          (rd_m),
    .PCPlus4M     (pc4_m),
    .dbus         (dbus),
    .StallM       (stall_w),
    .ResultW      (result_w),
    .RdW          (rd_w),
    .RegWriteW    (rw_w),
    .misalign_err (mis_w),
    .bus_err      (berr_w)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int stall_seen, valid_seen;
  bit check_en = 1'b0;

  logic        exp_stall, exp_valid, exp_we, exp_rw, exp_mis, exp_berr;
  logic [31:0] exp_addr, exp_wdata, exp_res;
  logic [4:0]  exp_rd;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit is_memop(input instr_t i);
    return i.we || (i.src == 2'b01);
  endfunction

  function automatic bit is_aligned(input instr_t i);
    return is_memop(i) && (i.alu[1:0] == 2'b00);
  endfunction

  function automatic bit is_mis(input instr_t i);
    return is_memop(i) && (i.alu[1:0] != 2'b00);
  endfunction

  // Cycles StallM stays high: issue (r+1) plus WAIT (d+1, or 255 on timeout).
  function automatic int stall_len(input instr_t i);
    if (!is_memop(i)) return 0;
    if (is_mis(i)) return 1;
    if (i.tmo) return i.r + 1 + 255;
    return i.r + 1 + i.d + 1;
  endfunction

  function automatic logic [31:0] exp_result(input instr_t i);
    case (i.src)
      2'b01:   return (is_aligned(i) && !i.tmo) ? i.rdata : 32'h0;
      2'b10:   return i.pc4;
      default: return i.alu;
    endcase
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk("StallM", {31'b0, stall_w}, {31'b0, exp_stall});
      chk("dreq_valid", {31'b0, dbus.dreq_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
        chk("dreq_addr", dbus.dreq_addr, exp_addr);
        chk("dreq_we", {31'b0, dbus.dreq_we}, {31'b0, exp_we});
        chk("dreq_wdata", dbus.dreq_wdata, exp_wdata);
      end
      chk("ResultW", result_w, exp_res);
      chk("RdW", {27'b0, rd_w}, {27'b0, exp_rd});
      chk("RegWriteW", {31'b0, rw_w}, {31'b0, exp_rw});
      chk("misalign_err", {31'b0, mis_w}, {31'b0, exp_mis});
      chk("bus_err", {31'b0, berr_w}, {31'b0, exp_berr});
    end
    if (stall_w) stall_seen++;
    if (dbus.dreq_valid) valid_seen++;
  end

  // Presents one instruction in M and plays the memory side from its planned delays.
  task automatic run_instr(input instr_t ins);
    int sl;
    bit al;
    sl = stall_len(ins);
    al = is_aligned(ins);
    stall_seen = 0;
    valid_seen = 0;
    alu_m      = ins.alu;
    wdata_m    = ins.wdata;
    pc4_m      = ins.pc4;
    src_m      = ins.src;
    memwrite_m = ins.we;
    regwrite_m = ins.rw;
    rd_m       = ins.rd;
    for (int k = 0; k <= sl; k++) begin
      if (al && k <= ins.r) dbus.dreq_ready = (k == ins.r);
      else dbus.dreq_ready = 1'($urandom_range(0, 1));
      if (al && k > ins.r && k < sl) begin
        if (!ins.tmo && k == ins.r + 1 + ins.d) begin
          dbus.drsp_valid = 1'b1;
          dbus.drsp_rdata = ins.rdata;
        end else begin
          dbus.drsp_valid = 1'b0;
          dbus.drsp_rdata = $urandom;
        end
      end else begin
        dbus.drsp_valid = ins.noisy ? 1'b1 : 1'($urandom_range(0, 1));
        dbus.drsp_rdata = ~ins.rdata;
      end
      exp_stall = (k < sl);
      exp_valid = al && (k <= ins.r);
      exp_addr  = {ins.alu[31:2], 2'b00};
      exp_we    = ins.we;
      exp_wdata = ins.wdata;
      @(posedge clk);
      #1;
      if (k < sl) begin
        exp_rw = 1'b0;
      end else begin
        exp_rw  = ins.rw && (ins.rd != 5'd0);
        exp_rd  = ins.rd;
        exp_res = exp_result(ins);
      end
      if (k == sl - 1) begin
        if (is_mis(ins)) exp_mis = 1'b1;
        if (al && ins.tmo) exp_berr = 1'b1;
      end
    end
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    int kind;
    kind    = int'($urandom_range(0, 9));
    i.alu   = $urandom;
    i.wdata = $urandom;
    i.pc4   = $urandom;
    i.rdata = $urandom;
    i.rw    = 1'($urandom_range(0, 1));
    i.rd    = 5'($urandom_range(0, 31));
    i.r     = int'($urandom_range(0, 3));
    i.d     = int'($urandom_range(0, 4));
    i.tmo   = ($urandom_range(0, 19) == 0);
    i.noisy = 1'($urandom_range(0, 1));
    i.we    = 1'b0;
    case (kind)
      0, 1: i.src = 2'b00;
      2:    i.src = 2'b11;
      3:    i.src = 2'b10;
      4, 5, 6: begin
        i.src        = 2'b01;
        i.alu[1:0]   = 2'b00;
      end
      7, 8: begin
        i.we         = 1'b1;
        i.src        = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
        i.alu[1:0]   = 2'b00;
      end
      default: begin
        i.we         = 1'($urandom_range(0, 1));
        i.src        = i.we ? 2'b00 : 2'b01;
        i.alu[1:0]   = 2'($urandom_range(1, 3));
      end
    endcase
    return i;
  endfunction

  instr_t base = '{alu: 32'h0, wdata: 32'h0, pc4: 32'h0, rdata: 32'h0, src: 2'b00, we: 1'b0,
                   rw: 1'b0, tmo: 1'b0, noisy: 1'b0, rd: 5'd0, r: 0, d: 0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    instr_t t;
    reset = 1'b1;
    alu_m = '0; wdata_m = '0; pc4_m = '0; src_m = '0;
    memwrite_m = 1'b0; regwrite_m = 1'b0; rd_m = '0;
    dbus.dreq_ready = 1'b0; dbus.drsp_valid = 1'b0; dbus.drsp_rdata = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset ResultW", result_w, 32'h0);
    chk("reset RdW", {27'b0, rd_w}, 32'h0);
    chk("reset RegWriteW", {31'b0, rw_w}, 32'h0);
    chk("reset misalign_err", {31'b0, mis_w}, 32'h0);
    chk("reset bus_err", {31'b0, berr_w}, 32'h0);
    chk("reset StallM", {31'b0, stall_w}, 32'h0);
    chk("reset dreq_valid", {31'b0, dbus.dreq_valid}, 32'h0);
    reset = 1'b0;
    exp_rw = 1'b0; exp_rd = '0; exp_res = '0; exp_mis = 1'b0; exp_berr = 1'b0;
    check_en = 1'b1;

    // ALU op retires with no stall.
    t = base; t.alu = 32'h1234; t.rd = 5'd5; t.rw = 1'b1;
    run_instr(t);
    chk("alu stall cycles", stall_seen, 32'd0);
    chk("alu ResultW", result_w, 32'h1234);
    chk("alu RdW", {27'b0, rd_w}, 32'd5);
    chk("alu RegWriteW", {31'b0, rw_w}, 32'd1);

    // Minimum-latency load.
    t = base; t.alu = 32'h100; t.src = 2'b01; t.rd = 5'd7; t.rw = 1'b1; t.rdata = 32'hDEADBEEF;
    run_instr(t);
    chk("load stall cycles", stall_seen, 32'd2);
    chk("load dreq_valid cycles", valid_seen, 32'd1);
    chk("load ResultW", result_w, 32'hDEADBEEF);
    chk("load RegWriteW", {31'b0, rw_w}, 32'd1);

    // Store with back-pressure then delayed ack.
    t = base; t.alu = 32'h200; t.wdata = 32'hA5A5A5A5; t.we = 1'b1; t.r = 3; t.d = 1;
    run_instr(t);
    chk("store dreq_valid cycles", valid_seen, 32'd4);
    chk("store stall cycles", stall_seen, 32'd6);

    // Misaligned load.
    t = base; t.alu = 32'h103; t.src = 2'b01; t.rd = 5'd3; t.rw = 1'b1; t.rdata = 32'h55AA55AA;
    run_instr(t);
    chk("misaligned dreq_valid cycles", valid_seen, 32'd0);
    chk("misaligned stall cycles", stall_seen, 32'd1);
    chk("misaligned misalign_err", {31'b0, mis_w}, 32'd1);
    chk("misaligned ResultW", result_w, 32'h0);

    // Load that never gets a response, then a load surrounded by stray responses.
    t = base; t.alu = 32'h300; t.src = 2'b01; t.rd = 5'd4; t.rw = 1'b1; t.tmo = 1'b1;
    t.noisy = 1'b1; t.rdata = 32'h0BADF00D;
    run_instr(t);
    chk("timeout stall cycles", stall_seen, 32'd256);
    chk("timeout bus_err", {31'b0, berr_w}, 32'd1);
    chk("timeout ResultW", result_w, 32'h0);
    t = base; t.alu = 32'h304; t.src = 2'b01; t.rd = 5'd6; t.rw = 1'b1; t.d = 2;
    t.noisy = 1'b1; t.rdata = 32'h11223344;
    run_instr(t);
    chk("stray rsp ignored ResultW", result_w, 32'h11223344);

    for (int n = 0; n < 150; n++) run_instr(rand_instr());

    // Reset in the middle of an outstanding load.
    check_en = 1'b0;
    alu_m = 32'h400; src_m = 2'b01; memwrite_m = 1'b0; regwrite_m = 1'b1; rd_m = 5'd9;
    dbus.dreq_ready = 1'b1; dbus.drsp_valid = 1'b0;
    @(posedge clk);
    #1 dbus.dreq_ready = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid-reset dreq_valid", {31'b0, dbus.dreq_valid}, 32'd0);
    chk("mid-reset StallM", {31'b0, stall_w}, 32'd1);
    chk("mid-reset ResultW", result_w, 32'h0);
    chk("mid-reset RegWriteW", {31'b0, rw_w}, 32'd0);
    chk("mid-reset misalign_err", {31'b0, mis_w}, 32'd0);
    chk("mid-reset bus_err", {31'b0, berr_w}, 32'd0);
    alu_m = '0; src_m = 2'b00; regwrite_m = 1'b0; rd_m = '0;
    dbus.drsp_valid = 1'b1; dbus.drsp_rdata = 32'hBADC0DE5;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 dbus.drsp_valid = 1'b0;
    chk("post-reset StallM", {31'b0, stall_w}, 32'd0);
    chk("post-reset ResultW", result_w, 32'h0);
    chk("post-reset RegWriteW", {31'b0, rw_w}, 32'd0);
    exp_rw = 1'b0; exp_rd = '0; exp_res = '0; exp_mis = 1'b0; exp_berr = 1'b0;
    check_en = 1'b1;
    t = base; t.alu = 32'h400; t.src = 2'b10; t.pc4 = 32'h40; t.rd = 5'd1; t.rw = 1'b1;
    run_instr(t);
    chk("jal ResultW", result_w, 32'h40);
    chk("jal RdW", {27'b0, rd_w}, 32'd1);
    chk("jal RegWriteW", {31'b0, rw_w}, 32'd1);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
